// File: rtl/m1_acc_arbiter.sv
// Round-robin arbiter sharing one M1 accumulate datapath among NREQ requesters.
// Optional shadow-accumulator overflow flag: define M1_ACC_ARBITER_OVF_EN.
module m1_acc_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] op_sel,
  input  logic [3*NREQ-1:0] op_a,
  input  logic [3*NREQ-1:0] op_b,
  input  logic              clr_req,
  output logic [NREQ-1:0]   gnt,
  output logic              clr_ack,
  output logic              dp_rst,
  output logic [1:0]        dp_sel,
  output logic [2:0]        dp_in1,
  output logic [2:0]        dp_in2,
  output logic              busy,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic              err_sel,
  output logic              ovf
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] rr;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          found;
  logic          xfer;
  logic          op_ok;
  logic [1:0]    w_sel;
  logic [2:0]    w_a;
  logic [2:0]    w_b;
  logic          inflight;

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    state_nxt = state;
    gnt       = '0;
    win       = rr;
    cand      = rr;
    found     = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = DRAIN;
        end else if (rst) begin
          for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(rr) + k) % NREQ);
            if (!found && req[cand]) begin
              found     = 1'b1;
              gnt[cand] = 1'b1;
              win       = cand;
            end
          end
        end
      end
      DRAIN:   state_nxt = CLEAR;
      CLEAR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sel = 2'd0;
    w_a   = 3'd0;
    w_b   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        w_sel = op_sel[2*i +: 2];
        w_a   = op_a[3*i +: 3];
        w_b   = op_b[3*i +: 3];
      end
    end
    xfer  = |gnt;
    op_ok = xfer && (w_sel != 2'd3);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      rr         <= PW'(NREQ - 1);
      dp_rst     <= 1'b1;
      dp_sel     <= 2'd0;
      dp_in1     <= 3'd0;
      dp_in2     <= 3'd0;
      issued_cnt <= '0;
      clr_ack    <= 1'b0;
      err_sel    <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      state    <= state_nxt;
      dp_rst   <= (state == CLEAR);
      clr_ack  <= (state == CLEAR);
      err_sel  <= xfer && (w_sel == 2'd3);
      inflight <= op_ok;
      if (xfer) begin
        rr <= win;
      end
      // An illegal sel==3 op is consumed but replaced by a NOP.
      if (op_ok) begin
        dp_sel <= w_sel;
        dp_in1 <= w_a;
        dp_in2 <= w_b;
      end else begin
        dp_sel <= 2'd0;
        dp_in1 <= 3'd0;
        dp_in2 <= 3'd0;
      end
      if (state == CLEAR) begin
        issued_cnt <= '0;
      end else if (op_ok && (issued_cnt != '1)) begin
        issued_cnt <= issued_cnt + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE) || inflight;

`ifdef M1_ACC_ARBITER_OVF_EN
  logic [6:0] shadow;
  logic [3:0] pair_sum;
  logic [3:0] op_val;
  logic [7:0] total;

  // The shadow sums the op sitting in dp_* at the same edge M1 adds it.
  always_comb begin
    pair_sum = {1'b0, dp_in1} + {1'b0, dp_in2};
    case (dp_sel)
      2'd0:    op_val = {1'b0, dp_in2};
      2'd1:    op_val = pair_sum;
      default: op_val = {1'b0, dp_in1};
    endcase
    total = {1'b0, shadow} + {4'b0000, op_val};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      shadow <= 7'd0;
      ovf    <= 1'b0;
    end else if (state == CLEAR) begin
      shadow <= 7'd0;
      ovf    <= 1'b0;
    end else if (inflight) begin
      shadow <= total[6:0];
      if (total[7]) begin
        ovf <= 1'b1;
      end
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/m1_acc_arbiter.md
Name: m1_acc_arbiter

Overview:
- Round-robin controller that shares one M1 accumulate datapath among NREQ requesters.
- Accepts accumulate ops (sel, operand A, operand B) over a req/gnt handshake.
- Drives the M1 control and operand inputs, issuing a NOP when idle, and sequences accumulator clear.
- Sits between the requester blocks and the M1 instance. Its dp_* outputs connect directly to M1 rst/sel/in1/in2 on the same clk.

Parameters:
NREQ, 4, number of requesters (2..8)
CNT_W, 8, width of the issued-op counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-low
req  in  NREQ  request per requester; held until granted
op_sel  in  2*NREQ  per-requester op code; requester i uses bits [2i+1:2i]
op_a  in  3*NREQ  per-requester operand A, drives M1 in1; bits [3i+2:3i]
op_b  in  3*NREQ  per-requester operand B, drives M1 in2; bits [3i+2:3i]
clr_req  in  1  request accumulator clear; level, held until clr_ack
gnt  out  NREQ  one-hot grant, combinational; transfer occurs when req[i] & gnt[i] at a rising edge
clr_ack  out  1  one-cycle pulse, clear complete
dp_rst  out  1  registered; drives M1 rst (active-high)
dp_sel  out  2  registered; drives M1 sel
dp_in1  out  3  registered; drives M1 in1
dp_in2  out  3  registered; drives M1 in2
busy  out  1  state != IDLE, or an op is in flight
issued_cnt  out  CNT_W  ops issued since reset or clear; saturates at all-ones
err_sel  out  1  one-cycle pulse, a granted op had sel==3
ovf  out  1  sticky accumulator wrap flag (see Optional Feature)

Behaviour:
- Reset (rst==0 at an edge):
  - state=IDLE, rr pointer=NREQ-1 (so requester 0 has highest priority).
  - dp_rst=1, dp_sel=0, dp_in1=0, dp_in2=0.
  - issued_cnt=0, clr_ack=0, err_sel=0, ovf=0.
  - gnt=0 while rst==0.
  - dp_rst falls to 0 on the first edge with rst==1.
- NOP encoding: dp_sel=0, dp_in2=0, dp_in1=0 (adds zero). Driven on every cycle with no transfer, so M1 never sees sel==3.
- States: IDLE, DRAIN, CLEAR.
- IDLE:
  - If clr_req==1: gnt=0 and go to DRAIN. Clear has priority over all requests in the same cycle.
  - Else: gnt selects the first req[i] set, searching from rr+1 modulo NREQ. No req means gnt=0.
- Transfer on requester w:
  - At that edge, dp_sel/dp_in1/dp_in2 register op_sel/op_a/op_b of w, and rr becomes w.
  - M1 adds the op at the next edge, so the accumulator reflects the op 2 edges after acceptance.
- sel==3 op: it is still granted and consumed, but converted to NOP. err_sel pulses on the following cycle and issued_cnt does not increment.
- Valid op: issued_cnt increments by 1, saturating at 2^CNT_W-1.
- DRAIN (1 cycle): gnt=0 and dp_* hold NOP, so any in-flight op lands in M1. Next state is CLEAR.
- CLEAR (1 cycle): dp_rst=1 registered, so M1 is reset from the following edge.
  - issued_cnt=0 and ovf=0.
  - Next state is IDLE; clr_ack pulses in the first IDLE cycle.
  - Grants resume in that cycle only if clr_req has dropped.
  - If clr_req is still high, a new clear sequence starts.
- Reset mid-sequence (rst low in DRAIN or CLEAR): full reset as above. clr_ack does not pulse.
- A requester dropping req without a grant is legal; nothing is recorded.
- gnt is always one-hot or zero. gnt[i] can be 1 only when req[i]==1.

Optional Feature:
- Macro: M1_ACC_ARBITER_OVF_EN.
- Defined:
  - A 7-bit shadow accumulator adds each issued op's value, zero-extended to 7 bits, where value = op_b (sel 0), op_a+op_b as 4 bits (sel 1), or op_a (sel 2).
  - The add happens at the edge that M1 adds the op.
  - ovf is set when the true sum exceeds 127, and stays set until reset or clear.
- Undefined: ovf is tied to 0 and no shadow logic is present.

Test Plan:
- Reset, then req=4'b0001 with op_sel[1:0]=1, op_a=3, op_b=4 → gnt=0001 in the first IDLE cycle; next cycle dp_sel=1, dp_in1=3, dp_in2=4; M1 out=7 one edge later; issued_cnt=1.
- req=4'b1111 held for 8 cycles → gnt sequence 0001,0010,0100,1000,0001,... with exactly one grant per cycle; issued_cnt=8.
- Requester 2 with op_sel=3 granted → dp_* is NOP, err_sel pulses once, issued_cnt unchanged, M1 out unchanged.
- clr_req=1 in the same cycle as req=0001 → gnt=0; DRAIN, then CLEAR with dp_rst=1 for 1 cycle; clr_ack pulses; M1 out=0, issued_cnt=0; the request is then granted.
- rst=0 asserted while in CLEAR → next cycle state IDLE, dp_rst=1, no clr_ack, gnt=0.
- With M1_ACC_ARBITER_OVF_EN defined, 19 ops of sel=1, a=3, b=4 → ovf=1 after the 19th op lands (sum 133, M1 out=5). Without the macro, ovf stays 0.
